// File: rtl/ext_int_ctrl.sv
// External interrupt controller: four synchronised, debounced pins with per-pin
// level/edge sensing, flags, mask and an I/O-bus register file (EICR/EIMSK/EIFR/EIPIN).
module ext_int_ctrl #(
    parameter logic [5:0]  base_addr  = 6'h1D,
    parameter int unsigned deb_cycles = 16,
    parameter int unsigned irq_base   = 1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [5:0] io_a,
    input  logic       io_we,
    input  logic       io_re,
    input  logic [7:0] io_di,
    output logic [7:0] io_do,
    input  logic       irq_ack,
    input  logic [3:0] irq_ack_ad,
    input  logic [3:0] ext_pin_i,
    output logic [3:0] ext_irq_o
);

    localparam logic [5:0] addr_eicr  = base_addr;
    localparam logic [5:0] addr_eimsk = base_addr + 6'd1;
    localparam logic [5:0] addr_eifr  = base_addr + 6'd2;
    localparam logic [5:0] addr_eipin = base_addr + 6'd3;
    localparam logic [7:0] deb_last   = (deb_cycles == 0) ? 8'd0 : 8'(deb_cycles - 1);

    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;
    logic [3:0] filt_q,  filt_d;
    logic [3:0] prev_q,  prev_d;
    logic [7:0] cnt_q [4];
    logic [7:0] cnt_d [4];
    logic [7:0] eicr_q,  eicr_d;
    logic [3:0] eimsk_q, eimsk_d;
    logic [3:0] flag_q,  flag_d;
    logic [3:0] irq_q,   irq_d;
    logic [7:0] io_do_q, io_do_d;

    logic       sel_eicr, sel_eimsk, sel_eifr, sel_eipin;
    logic       eicr_wr, eimsk_wr, eifr_wr;
    logic [3:0] ack_hit;
    logic [3:0] eifr_view;

    assign sel_eicr  = (io_a == addr_eicr);
    assign sel_eimsk = (io_a == addr_eimsk);
    assign sel_eifr  = (io_a == addr_eifr);
    assign sel_eipin = (io_a == addr_eipin);
    assign eicr_wr   = io_we & sel_eicr;
    assign eimsk_wr  = io_we & sel_eimsk;
    assign eifr_wr   = io_we & sel_eifr;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ack
            assign ack_hit[gi] = irq_ack & (irq_ack_ad == 4'(irq_base + gi));
        end
    endgenerate

    always_comb begin
        logic [1:0] mode;
        logic       prev_eff;
        logic       evt;
        logic       clr;
        logic       req;

        sync1_d   = ext_pin_i;
        sync2_d   = sync1_q;
        filt_d    = filt_q;
        prev_d    = filt_q;
        eicr_d    = eicr_wr ? io_di : eicr_q;
        eimsk_d   = eimsk_wr ? io_di[3:0] : eimsk_q;
        flag_d    = flag_q;
        irq_d     = '0;
        eifr_view = '0;
        mode      = 2'b00;
        prev_eff  = 1'b1;
        evt       = 1'b0;
        clr       = 1'b0;
        req       = 1'b0;

        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (deb_cycles == 0) begin
                filt_d[i] = sync2_q[i];
                cnt_d[i]  = '0;
            end else if (sync2_q[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == deb_last) begin
                filt_d[i] = sync2_q[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end

            // An EICR write aligns prev with filt so the mode switch cannot fake an edge.
            mode     = eicr_q[2*i +: 2];
            prev_eff = eicr_wr ? filt_q[i] : prev_q[i];
            case (mode)
                2'b01:   evt = filt_q[i] ^ prev_eff;
                2'b10:   evt = prev_eff & ~filt_q[i];
                2'b11:   evt = ~prev_eff & filt_q[i];
                default: evt = 1'b0;
            endcase

            clr = (eifr_wr & io_di[i]) | ack_hit[i];
            if (mode != 2'b00) begin
                flag_d[i] = evt | (flag_q[i] & ~clr);
            end
            req          = (mode == 2'b00) ? ~filt_q[i] : flag_q[i];
            eifr_view[i] = req;
            irq_d[i]     = eimsk_q[i] & req;
        end

        io_do_d = '0;
        if (io_re) begin
            if (sel_eicr)       io_do_d = eicr_q;
            else if (sel_eimsk) io_do_d = {4'b0, eimsk_q};
            else if (sel_eifr)  io_do_d = {4'b0, eifr_view};
            else if (sel_eipin) io_do_d = {4'b0, filt_q};
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            filt_q  <= '1;
            prev_q  <= '1;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            eicr_q  <= '0;
            eimsk_q <= '0;
            flag_q  <= '0;
            irq_q   <= '0;
            io_do_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            prev_q  <= prev_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            eicr_q  <= eicr_d;
            eimsk_q <= eimsk_d;
            flag_q  <= flag_d;
            irq_q   <= irq_d;
            io_do_q <= io_do_d;
        end
    end

    assign io_do     = io_do_q;
    assign ext_irq_o = irq_q;

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Directed bench for ext_int_ctrl: edge/level sensing, debounce, flags, mask and reset.
`timescale 1ns/1ps
module tb_ext_int_ctrl;

    localparam logic [5:0] A_EICR  = 6'h1D;
    localparam logic [5:0] A_EIMSK = 6'h1E;
    localparam logic [5:0] A_EIFR  = 6'h1F;
    localparam logic [5:0] A_EIPIN = 6'h20;

    logic       sys_clk    = 1'b0;
    logic       sys_rst_n  = 1'b0;
    logic [5:0] io_a       = '0;
    logic       io_we      = 1'b0;
    logic       io_re      = 1'b0;
    logic [7:0] io_di      = '0;
    logic [7:0] io_do;
    logic       irq_ack    = 1'b0;
    logic [3:0] irq_ack_ad = '0;
    logic [3:0] ext_pin_i  = 4'hF;
    logic [3:0] ext_irq_o;

    int n_tests = 0;
    int n_fail  = 0;

    ext_int_ctrl dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .io_a       (io_a),
        .io_we      (io_we),
        .io_re      (io_re),
        .io_di      (io_di),
        .io_do      (io_do),
        .irq_ack    (irq_ack),
        .irq_ack_ad (irq_ack_ad),
        .ext_pin_i  (ext_pin_i),
        .ext_irq_o  (ext_irq_o)
    );

    always #50 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %02h", tag, got);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic wr(input logic [5:0] addr, input logic [7:0] data);
        io_a  = addr;
        io_di = data;
        io_we = 1'b1;
        tick();
        io_we = 1'b0;
        io_di = '0;
    endtask

    task automatic rd_check(input string tag, input logic [5:0] addr, input logic [7:0] exp);
        io_a  = addr;
        io_re = 1'b1;
        tick();
        io_re = 1'b0;
        check(tag, io_do, exp);
    endtask

    task automatic ack(input logic [3:0] code);
        irq_ack    = 1'b1;
        irq_ack_ad = code;
        tick();
        irq_ack    = 1'b0;
        irq_ack_ad = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Power-on reset
        #10;
        check("rst_io_do", io_do, 8'h00);
        check("rst_irq", {4'b0, ext_irq_o}, 8'h00);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tick();
        rd_check("rst_eipin", A_EIPIN, 8'h0F);
        rd_check("rst_eifr", A_EIFR, 8'h00);

        // Falling edge on pin 0, 20-cycle latency, then ack code 1
        wr(A_EICR, 8'h02);
        wr(A_EIMSK, 8'h01);
        ext_pin_i[0] = 1'b0;
        tick(19);
        check("fall_irq_at19", {4'b0, ext_irq_o}, 8'h00);
        tick(1);
        check("fall_irq_at20", {4'b0, ext_irq_o}, 8'h01);
        rd_check("fall_eifr", A_EIFR, 8'h01);
        ack(4'd1);
        tick();
        check("fall_irq_acked", {4'b0, ext_irq_o}, 8'h00);
        rd_check("fall_eifr_acked", A_EIFR, 8'h00);
        ext_pin_i[0] = 1'b1;
        tick(25);
        rd_check("fall_no_rise_flag", A_EIFR, 8'h00);

        // Glitch rejection on pin 2
        wr(A_EICR, 8'h20);
        wr(A_EIMSK, 8'h00);
        ext_pin_i[2] = 1'b0;
        tick(15);
        ext_pin_i[2] = 1'b1;
        tick(25);
        rd_check("glitch15_eifr", A_EIFR, 8'h00);
        rd_check("glitch15_eipin", A_EIPIN, 8'h0F);
        ext_pin_i[2] = 1'b0;
        tick(16);
        ext_pin_i[2] = 1'b1;
        tick(25);
        rd_check("pulse16_eifr", A_EIFR, 8'h04);
        wr(A_EIFR, 8'h04);
        rd_check("pulse16_w1c", A_EIFR, 8'h00);

        // Level mode on pin 3 with mask
        wr(A_EICR, 8'h00);
        wr(A_EIMSK, 8'hFF);
        rd_check("eimsk_upper", A_EIMSK, 8'h0F);
        wr(A_EIMSK, 8'h08);
        ext_pin_i[3] = 1'b0;
        tick(20);
        check("level_irq", {4'b0, ext_irq_o}, 8'h08);
        rd_check("level_eifr", A_EIFR, 8'h08);
        rd_check("level_eipin", A_EIPIN, 8'h07);
        wr(A_EIPIN, 8'h00);
        rd_check("eipin_ro", A_EIPIN, 8'h07);
        wr(A_EIFR, 8'h08);
        check("level_w1c_irq", {4'b0, ext_irq_o}, 8'h08);
        rd_check("level_w1c_eifr", A_EIFR, 8'h08);
        ext_pin_i[3] = 1'b1;
        tick(18);
        check("level_rel_at18", {4'b0, ext_irq_o}, 8'h08);
        tick(1);
        check("level_rel_at19", {4'b0, ext_irq_o}, 8'h00);

        // Set/clear collision on pin 1 (any edge)
        wr(A_EIMSK, 8'h00);
        wr(A_EICR, 8'h04);
        ext_pin_i[1] = 1'b0;
        tick(18);
        wr(A_EIFR, 8'h02);
        rd_check("collide_eifr", A_EIFR, 8'h02);
        wr(A_EIFR, 8'h02);
        rd_check("collide_w1c", A_EIFR, 8'h00);
        ext_pin_i[1] = 1'b1;
        tick(25);
        rd_check("anyedge_rise", A_EIFR, 8'h02);
        wr(A_EIFR, 8'h02);
        rd_check("anyedge_w1c", A_EIFR, 8'h00);

        // Mode change while pin 0 is filtered low
        wr(A_EICR, 8'h00);
        ext_pin_i[0] = 1'b0;
        tick(20);
        rd_check("mode_level_view", A_EIFR, 8'h01);
        wr(A_EICR, 8'h03);
        rd_check("mode_change_noflag", A_EIFR, 8'h00);
        ext_pin_i[0] = 1'b1;
        tick(20);
        rd_check("mode_rise_flag", A_EIFR, 8'h01);
        ack(4'd2);
        rd_check("ack_wrong_code", A_EIFR, 8'h01);
        ack(4'd1);
        rd_check("ack_right_code", A_EIFR, 8'h00);

        // Reset in the middle of operation
        wr(A_EICR, 8'h00);
        wr(A_EIMSK, 8'h0F);
        ext_pin_i[3] = 1'b0;
        tick(20);
        check("pre_rst_irq", {4'b0, ext_irq_o}, 8'h08);
        io_a  = A_EIPIN;
        io_re = 1'b1;
        tick();
        check("pre_rst_io_do", io_do, 8'h07);
        #20;
        sys_rst_n = 1'b0;
        #1;
        check("midrst_io_do", io_do, 8'h00);
        check("midrst_irq", {4'b0, ext_irq_o}, 8'h00);
        io_re = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tick();
        rd_check("postrst_eipin", A_EIPIN, 8'h0F);
        rd_check("postrst_eicr", A_EICR, 8'h00);
        rd_check("postrst_eimsk", A_EIMSK, 8'h00);
        check("postrst_irq", {4'b0, ext_irq_o}, 8'h00);
        ext_pin_i[3] = 1'b1;
        tick(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
